// File: rtl/mmio_input_port_pkg.sv
`default_nettype none
// ============================================================================
// mmio_pkg : shared addresses, word field positions and input numbering
// Rev 1.0  initial release
// ============================================================================
package mmio_pkg;

   localparam int STATUS_ADDR = 97;
   localparam int EVENT_ADDR  = 98;
   localparam int RNG_ADDR    = 99;

   localparam int NUM_INPUTS = 6;
   localparam int IDX_BTNL   = 0;
   localparam int IDX_SW0    = 1;

   localparam int EVT_VALID_BIT = 31;
   localparam int EVT_LEVEL_BIT = 8;
   localparam int EVT_IDX_LSB   = 0;
   localparam int EVT_IDX_W     = 3;

   localparam int STAT_OVF_BIT = 16;
   localparam int STAT_CNT_LSB = 8;
   localparam int STAT_CNT_W   = 3;
   localparam int STAT_LVL_LSB = 0;

   function automatic logic [31:0] make_event(input logic level, input logic [EVT_IDX_W-1:0] idx);
      logic [31:0] w;
      w                              = '0;
      w[EVT_VALID_BIT]               = 1'b1;
      w[EVT_LEVEL_BIT]               = level;
      w[EVT_IDX_LSB +: EVT_IDX_W]    = idx;
      return w;
   endfunction

   function automatic logic [31:0] make_status(input logic ovf, input logic [STAT_CNT_W-1:0] cnt,
                                               input logic [NUM_INPUTS-1:0] lv);
      logic [31:0] w;
      w                              = '0;
      w[STAT_OVF_BIT]                = ovf;
      w[STAT_CNT_LSB +: STAT_CNT_W]  = cnt;
      w[STAT_LVL_LSB +: NUM_INPUTS]  = lv;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_input_port_if.sv
`default_nettype none
// ============================================================================
// mmio_input_port_if : dmem-side bus of the input peripheral
// Rev 1.0  initial release
// ============================================================================
interface mmio_input_port_if;
   logic [31:0] addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] rd_data;
   logic        event_pending;

   modport master (output addr, rd_en, wr_en, input rd_data, event_pending);
   modport slave  (input addr, rd_en, wr_en, output rd_data, event_pending);
endinterface
`default_nettype wire

// File: rtl/mmio_input_port_debouncer.sv
`default_nettype none
// ============================================================================
// debouncer : two-flop synchronizer plus counter debounce for one raw input
// Rev 1.0  initial release
// ============================================================================
module debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  wire  clk,
   input  wire  rst,
   input  wire  raw,
   output logic stable,
   output logic change
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   // one-cycle strobe on the edge where the new level is accepted
   assign change = (sync != stable) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         if (sync == stable || change)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (change)
            stable <= sync;
      end
   end
endmodule
`default_nettype wire

// File: rtl/mmio_input_port.sv
`default_nettype none
// ============================================================================
// mmio_input_port : debounced button/switch levels with an event FIFO on dmem
// Rev 1.0  initial release
// ============================================================================
module mmio_input_port #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int FIFO_DEPTH      = 4,
   parameter int STATUS_ADDR     = mmio_pkg::STATUS_ADDR,
   parameter int EVENT_ADDR      = mmio_pkg::EVENT_ADDR
) (
   input  wire              clock,
   input  wire              reset,
   input  wire              BTNL,
   input  wire  [4:0]       SW,
   mmio_input_port_if.slave bus
);
   localparam int NIN = mmio_pkg::NUM_INPUTS;
   localparam int AW  = $clog2(FIFO_DEPTH);

   logic [NIN-1:0] raw, stable, change, pend, grant;
   logic [2:0]     sel_idx;
   logic [31:0]    ev_word;
   logic [31:0]    mem [FIFO_DEPTH];
   logic [AW:0]    wptr, rptr, count;
   logic           ovf, empty, full, ev_sel, push, pop, flush, do_write;

   assign raw = {SW, BTNL};

   generate
      for (genvar i = 0; i < NIN; i++) begin : g_deb
         debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clock),
            .rst    (reset),
            .raw    (raw[i]),
            .stable (stable[i]),
            .change (change[i])
         );
      end
   endgenerate

   // lowest pending index wins; grant isolates its bit
   always_comb begin
      sel_idx = '0;
      for (int i = NIN - 1; i >= 0; i--)
         if (pend[i]) sel_idx = 3'(i);
   end
   assign grant   = pend & (~pend + NIN'(1));
   assign push    = |pend;
   assign ev_word = mmio_pkg::make_event(stable[sel_idx], sel_idx);

   assign count    = wptr - rptr;
   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign ev_sel   = (bus.addr == 32'(EVENT_ADDR));
   assign pop      = bus.rd_en && ev_sel && !empty;
   assign flush    = bus.wr_en && ev_sel;
   assign do_write = push && (!full || pop) && !flush;

   always_ff @(posedge clock) begin
      if (reset) begin
         pend <= '0;
         ovf  <= 1'b0;
         wptr <= '0;
         rptr <= '0;
      end else begin
         pend <= (pend & ~grant) | change;
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
         end else begin
            if (do_write) wptr <= wptr + (AW+1)'(1);
            if (pop)      rptr <= rptr + (AW+1)'(1);
            if (push && full && !pop) ovf <= 1'b1;
         end
      end
   end

   // when full, a simultaneous pop frees the very slot being written
   always_ff @(posedge clock) begin
      if (do_write) mem[wptr[AW-1:0]] <= ev_word;
   end

   always_comb begin
      bus.rd_data = '0;
      if (bus.addr == 32'(STATUS_ADDR))
         bus.rd_data = mmio_pkg::make_status(ovf, 3'(count), stable);
      else if (ev_sel && !empty)
         bus.rd_data = mem[rptr[AW-1:0]];
   end

   assign bus.event_pending = !empty;
endmodule
`default_nettype wire

// File: tb/tb_mmio_input_port.sv
`default_nettype none
// ============================================================================
// tb_mmio_input_port : directed plus random stimulus against a queue model
// Rev 1.0  initial release
// ============================================================================
module tb_mmio_input_port;
   localparam int DB = 4;
   localparam int SA = 97;
   localparam int EA = 98;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] raw = '0;

   mmio_input_port_if bus ();

   mmio_input_port #(
      .DEBOUNCE_CYCLES (DB),
      .FIFO_DEPTH      (4),
      .STATUS_ADDR     (SA),
      .EVENT_ADDR      (EA)
   ) dut (
      .clock (clk),
      .reset (rst),
      .BTNL  (raw[0]),
      .SW    (raw[5:1]),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   logic [5:0]  ms   = '0;
   logic        movf = 1'b0;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int a, output logic [31:0] d);
      bus.addr = 32'(a);
      #1;
      d = bus.rd_data;
   endtask

   function automatic logic [31:0] head();
      return (q.size() != 0) ? q[0] : 32'h0;
   endfunction

   function automatic logic [31:0] exp_status();
      return (32'(movf) << 16) | (32'(q.size()) << 8) | 32'(ms);
   endfunction

   task automatic chk_status(input string tag);
      logic [31:0] d;
      rd(SA, d);
      chk(tag, d, exp_status());
   endtask

   task automatic chk_head(input string tag);
      logic [31:0] d;
      rd(EA, d);
      chk(tag, d, head());
      chk({tag, "_pend"}, 32'(bus.event_pending), 32'(q.size() != 0));
   endtask

   task automatic model_push(input int idx);
      logic [31:0] w;
      w = 32'h8000_0000 | (32'(ms[idx]) << 8) | 32'(idx);
      if (q.size() == 4) movf = 1'b1;
      else               q.push_back(w);
   endtask

   task automatic toggle(input int idx);
      raw[idx] = ~raw[idx];
      ms[idx]  = raw[idx];
      model_push(idx);
      step(10);
   endtask

   task automatic pop(input string tag);
      bus.addr  = 32'(EA);
      bus.rd_en = 1'b1;
      #1;
      chk(tag, bus.rd_data, head());
      @(negedge clk);
      bus.rd_en = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic flush();
      bus.addr  = 32'(EA);
      bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      q.delete();
      movf = 1'b0;
   endtask

   initial begin
      int idx, len;
      bus.addr = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);
      chk_status("reset_status");
      chk_head("reset_event");

      // button press: invisible after 6 edges, visible after 7
      raw[0] = 1'b1; ms[0] = 1'b1;
      step(6);
      chk("btnl_early_pend", 32'(bus.event_pending), 32'h0);
      step(1);
      model_push(0);
      chk_head("btnl_event");
      chk("btnl_word", head(), 32'h8000_0100);
      chk_status("btnl_status");
      pop("btnl_pop");
      chk_head("btnl_empty");

      // 3-cycle glitch on SW[2]
      raw[3] = 1'b1; step(3); raw[3] = 1'b0;
      step(12);
      chk_status("glitch_status");

      // SW[0] and SW[4] together
      raw[1] = 1'b1; raw[5] = 1'b1; ms[1] = 1'b1; ms[5] = 1'b1;
      step(7);
      model_push(1);
      chk_head("dual_first");
      chk_status("dual_count1");
      step(1);
      model_push(5);
      chk_status("dual_count2");
      pop("dual_pop1");
      pop("dual_pop2");

      // overflow then flush
      toggle(1); toggle(5); toggle(0); toggle(2); toggle(4);
      chk_status("ovf_status");
      for (int i = 0; i < 4; i++) pop("ovf_order");
      chk_status("ovf_sticky");
      toggle(3); toggle(3);
      flush();
      chk_status("flush_status");
      chk_head("flush_empty");

      // full FIFO: pop and push on the same edge
      toggle(1); toggle(2); toggle(3); toggle(4);
      raw[5] = ~raw[5]; ms[5] = raw[5];
      step(6);
      bus.addr = 32'(EA); bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      void'(q.pop_front());
      model_push(5);
      step(2);
      chk_status("full_pp_status");
      for (int i = 0; i < 4; i++) pop("full_pp_order");

      // random traffic
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0, 1: toggle(int'($urandom_range(0, 5)));
            2: begin
               idx = int'($urandom_range(0, 5));
               len = int'($urandom_range(1, 3));
               raw[idx] = ~raw[idx]; step(len); raw[idx] = ~raw[idx];
               step(10);
            end
            default: begin
               if ($urandom_range(0, 3) == 0) flush();
               else                           pop("rnd_pop");
            end
         endcase
         chk_status("rnd_status");
      end

      // reset with inputs already on
      raw = 6'b101101;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      q.delete(); movf = 1'b0; ms = '0;
      chk_status("rst2_status");
      ms = raw;
      for (int i = 0; i < 6; i++) if (raw[i]) model_push(i);
      step(16);
      chk_status("rst2_events");
      for (int i = 0; i < 4; i++) pop("rst2_order");
      chk_head("rst2_empty");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
